// File: rtl/vend_pkg.sv
// Shared types for the vending engine: FSM states, result codes and item entry layout.
package vend_pkg;

  localparam int unsigned ENTRY_W   = 32;
  localparam int unsigned PRICE_LSB = 0;
  localparam int unsigned PRICE_W   = 16;
  localparam int unsigned STOCK_LSB = 16;
  localparam int unsigned STOCK_W   = 8;
  localparam int unsigned SOLD_LSB  = 24;
  localparam int unsigned SOLD_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECTED = 2'd1,
    S_RESULT   = 2'd2,
    S_CFG      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DISPENSED = 2'd0,
    CANCEL    = 2'd1,
    TIMEOUT   = 2'd2,
    SOLD_OUT  = 2'd3
  } status_e;

  // Field order mirrors the offsets above: sold[31:24], stock[23:16], price[15:0].
  typedef struct packed {
    logic [SOLD_W-1:0]  sold;
    logic [STOCK_W-1:0] stock;
    logic [PRICE_W-1:0] price;
  } item_entry_t;

endpackage

// File: rtl/vend_if.sv
// Config, selection, coin and result signals of the vending engine.
interface vend_if #(
  parameter int unsigned NUM_ITEMS = 64,
  parameter int unsigned CREDIT_W  = 12
);
  localparam int unsigned IW = $clog2(NUM_ITEMS);

  logic                cfg_en;
  logic                cfg_we;
  logic                cfg_rd;
  logic [IW-1:0]       cfg_addr;
  logic [31:0]         cfg_wdata;
  logic [31:0]         cfg_rdata;
  logic                cfg_rvalid;

  logic                sel_valid;
  logic [IW-1:0]       sel_item;
  logic                cancel;

  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                coin_rej;

  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_item;
  logic [1:0]          out_status;
  logic [CREDIT_W-1:0] out_change;

  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output cfg_en, cfg_we, cfg_rd, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid,
    output sel_valid, sel_item, cancel,
    output coin_valid, coin_value,
    input  coin_rej,
    input  out_valid, out_item, out_status, out_change,
    output out_ready,
    input  credit, busy
  );

  modport slave (
    input  cfg_en, cfg_we, cfg_rd, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid,
    input  sel_valid, sel_item, cancel,
    input  coin_valid, coin_value,
    output coin_rej,
    output out_valid, out_item, out_status, out_change,
    input  out_ready,
    output credit, busy
  );
endinterface

// File: rtl/vend_item_ram.sv
// Item table: one write port, one read port with a registered (1-cycle) read; cleared on reset.
module vend_item_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vend_engine.sv
// Vending engine: credit accumulation, selection, dispense/refund/timeout results and item config.
module vend_engine
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 64,
  parameter int unsigned CREDIT_W    = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic   clk,
  input logic   rstn,
  vend_if.slave bus
);

  localparam int unsigned IW    = $clog2(NUM_ITEMS);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CMP_W = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;

  state_e              state, state_nxt;
  logic [IW-1:0]       cur_item;
  logic [TW-1:0]       tmo_cnt;

  logic                wr_en;
  logic [IW-1:0]       wr_addr;
  item_entry_t         wr_data;
  logic [IW-1:0]       rd_addr;
  logic [ENTRY_W-1:0]  ram_rdata;
  item_entry_t         ent;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_good;
  logic                coin_acc;
  logic                coin_rej_nxt;
  logic                item_ld;
  logic                tmo_clr;
  logic                out_done;
  logic                res_go;
  status_e             res_status;
  logic [IW-1:0]       res_item;
  logic [CREDIT_W-1:0] res_change;
  logic [CMP_W-1:0]    price_ext;
  logic [CMP_W-1:0]    credit_ext;

  vend_item_ram #(
    .DEPTH (NUM_ITEMS),
    .AW    (IW),
    .DW    (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // The read port follows the selected item while SELECTED, so the entry is always current there.
  assign ent            = item_entry_t'(ram_rdata);
  assign bus.cfg_rdata  = ram_rdata;
  assign price_ext      = CMP_W'(ent.price);
  assign credit_ext     = CMP_W'(bus.credit);
  assign coin_sum       = {1'b0, bus.credit} + {1'b0, bus.coin_value};
  assign coin_good      = bus.coin_valid && (bus.coin_value != '0) && !coin_sum[CREDIT_W];
  assign out_done       = (state == S_RESULT) && bus.out_ready;

  // Event decode and next state; priority cancel > sold-out/dispense > coin > timeout.
  always_comb begin
    state_nxt    = state;
    wr_en        = 1'b0;
    wr_addr      = bus.cfg_addr;
    wr_data      = item_entry_t'(bus.cfg_wdata);
    rd_addr      = bus.cfg_addr;
    coin_acc     = 1'b0;
    coin_rej_nxt = 1'b0;
    item_ld      = 1'b0;
    tmo_clr      = 1'b0;
    res_go       = 1'b0;
    res_status   = DISPENSED;
    res_item     = cur_item;
    res_change   = bus.credit;

    case (state)
      S_IDLE: begin
        wr_en = bus.cfg_en && bus.cfg_we;
        if (bus.cancel && (bus.credit != '0)) begin
          res_go       = 1'b1;
          res_status   = CANCEL;
          res_item     = IW'(NUM_ITEMS - 1);
          coin_rej_nxt = bus.coin_valid;
        end else begin
          coin_acc     = coin_good;
          coin_rej_nxt = bus.coin_valid && !coin_good;
          if (bus.sel_valid) begin
            state_nxt = S_SELECTED;
            rd_addr   = bus.sel_item;
            item_ld   = 1'b1;
            tmo_clr   = 1'b1;
          end else if (bus.cfg_en) begin
            state_nxt = S_CFG;
          end
        end
      end

      S_CFG: begin
        wr_en        = bus.cfg_en && bus.cfg_we;
        coin_rej_nxt = bus.coin_valid;
        if (!bus.cfg_en) state_nxt = S_IDLE;
      end

      S_SELECTED: begin
        rd_addr = cur_item;
        if (bus.cancel) begin
          res_go       = 1'b1;
          res_status   = CANCEL;
          coin_rej_nxt = bus.coin_valid;
        end else if (ent.stock == '0) begin
          res_go       = 1'b1;
          res_status   = SOLD_OUT;
          coin_rej_nxt = bus.coin_valid;
        end else if (credit_ext >= price_ext) begin
          res_go        = 1'b1;
          res_status    = DISPENSED;
          res_change    = CREDIT_W'(credit_ext - price_ext);
          wr_en         = 1'b1;
          wr_addr       = cur_item;
          wr_data.price = ent.price;
          wr_data.stock = ent.stock - 8'd1;
          wr_data.sold  = (ent.sold == 8'hFF) ? 8'hFF : ent.sold + 8'd1;
          coin_rej_nxt  = bus.coin_valid;
        end else if (coin_good) begin
          coin_acc = 1'b1;
          tmo_clr  = 1'b1;
        end else begin
          coin_rej_nxt = bus.coin_valid;
          if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            res_go     = 1'b1;
            res_status = TIMEOUT;
          end
        end
      end

      S_RESULT: begin
        coin_rej_nxt = bus.coin_valid;
        if (bus.out_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    if (res_go) state_nxt = S_RESULT;
  end

  // State, credit, timeout and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      cur_item       <= '0;
      tmo_cnt        <= '0;
      bus.credit     <= '0;
      bus.busy       <= 1'b0;
      bus.coin_rej   <= 1'b0;
      bus.cfg_rvalid <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_item   <= '0;
      bus.out_status <= '0;
      bus.out_change <= '0;
    end else begin
      state          <= state_nxt;
      bus.busy       <= (state_nxt != S_IDLE);
      bus.coin_rej   <= coin_rej_nxt;
      bus.cfg_rvalid <= bus.cfg_rd;

      if (item_ld) cur_item <= bus.sel_item;

      if (out_done)      bus.credit <= '0;
      else if (coin_acc) bus.credit <= coin_sum[CREDIT_W-1:0];

      if (tmo_clr)                  tmo_cnt <= '0;
      else if (state == S_SELECTED) tmo_cnt <= tmo_cnt + TW'(1);

      if (res_go) begin
        bus.out_valid  <= 1'b1;
        bus.out_item   <= res_item;
        bus.out_status <= res_status;
        bus.out_change <= res_change;
      end else if (out_done) begin
        bus.out_valid  <= 1'b0;
        bus.out_item   <= '0;
        bus.out_status <= '0;
        bus.out_change <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vend_engine.sv
// Directed bench for vend_engine with hand-computed expectations.
module tb_vend_engine;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  vend_if #(.NUM_ITEMS(64), .CREDIT_W(12)) vif ();

  vend_engine #(
    .NUM_ITEMS   (64),
    .CREDIT_W    (12),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    vif.cfg_we    = 1'b1;
    vif.cfg_addr  = addr;
    vif.cfg_wdata = data;
    step();
    vif.cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [5:0] addr);
    vif.cfg_rd   = 1'b1;
    vif.cfg_addr = addr;
    step();
    vif.cfg_rd   = 1'b0;
  endtask

  task automatic select(input logic [5:0] item);
    vif.sel_valid = 1'b1;
    vif.sel_item  = item;
    step();
    vif.sel_valid = 1'b0;
  endtask

  task automatic coin(input logic [11:0] value);
    vif.coin_valid = 1'b1;
    vif.coin_value = value;
    step();
    vif.coin_valid = 1'b0;
    vif.coin_value = '0;
  endtask

  task automatic handshake();
    vif.out_ready = 1'b1;
    step();
    vif.out_ready = 1'b0;
  endtask

  // {out_valid, out_status, out_item, out_change} packed for single compares.
  function automatic logic [31:0] res_word(input logic v, input logic [1:0] st,
                                           input logic [5:0] item, input logic [11:0] chg);
    return {11'd0, v, st, item, chg};
  endfunction

  function automatic logic [31:0] dut_res();
    return res_word(vif.out_valid, vif.out_status, vif.out_item, vif.out_change);
  endfunction

  initial begin
    logic seen_valid;
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    vif.cfg_en = 1'b0; vif.cfg_we = 1'b0; vif.cfg_rd = 1'b0;
    vif.cfg_addr = '0; vif.cfg_wdata = '0;
    vif.sel_valid = 1'b0; vif.sel_item = '0; vif.cancel = 1'b0;
    vif.coin_valid = 1'b0; vif.coin_value = '0; vif.out_ready = 1'b0;

    step(3);
    check_val("rst_outputs",
              {vif.out_valid, vif.busy, vif.coin_rej, vif.cfg_rvalid, 12'(vif.credit)}, 32'd0);
    check_val("rst_rdata", vif.cfg_rdata, 32'd0);
    rstn = 1'b1;
    step();

    // Configure items: 3 = price 35 stock 2, 5 = price 20 stock 0, 7 = price 50 stock 9, 9 = price 0 stock 1.
    vif.cfg_en = 1'b1;
    cfg_write(6'd3, 32'h0002_0023);
    check_val("cfg_busy", vif.busy, 32'd1);
    cfg_write(6'd5, 32'h0000_0014);
    cfg_write(6'd7, 32'h0009_0032);
    cfg_write(6'd9, 32'h0001_0000);
    cfg_read(6'd3);
    check_val("cfg_rd_item3", {vif.cfg_rvalid, vif.cfg_rdata[30:0]}, 32'h8002_0023);
    step();
    check_val("cfg_rvalid_drop", vif.cfg_rvalid, 32'd0);
    vif.cfg_en = 1'b0;
    step(2);
    check_val("cfg_exit_busy", vif.busy, 32'd0);

    // Purchase with two coins.
    select(6'd3);
    check_val("sel_busy", vif.busy, 32'd1);
    coin(12'd20);
    check_val("credit_20", vif.credit, 32'd20);
    coin(12'd20);
    check_val("credit_40", {vif.out_valid, 12'(vif.credit)}, 32'd40);
    step();
    check_val("dispense", dut_res(), res_word(1'b1, 2'd0, 6'd3, 12'd5));
    handshake();
    check_val("disp_done", {vif.out_valid, vif.busy, 12'(vif.credit)}, 32'd0);
    cfg_read(6'd3);
    check_val("disp_readback", vif.cfg_rdata, 32'h0101_0023);

    // Sold out leaves the entry alone.
    select(6'd5);
    step();
    check_val("sold_out", dut_res(), res_word(1'b1, 2'd3, 6'd5, 12'd0));
    handshake();
    cfg_read(6'd5);
    check_val("sold_out_entry", vif.cfg_rdata, 32'h0000_0014);

    // Cancel after a partial payment.
    select(6'd7);
    coin(12'd10);
    check_val("cancel_credit", vif.credit, 32'd10);
    vif.cancel = 1'b1;
    step();
    vif.cancel = 1'b0;
    check_val("cancel_res", dut_res(), res_word(1'b1, 2'd1, 6'd7, 12'd10));
    handshake();
    check_val("cancel_clr", vif.credit, 32'd0);

    // Timeout 16 idle cycles after the last coin.
    select(6'd7);
    coin(12'd5);
    step(15);
    check_val("tmo_not_yet", vif.out_valid, 32'd0);
    step();
    check_val("tmo_res", dut_res(), res_word(1'b1, 2'd2, 6'd7, 12'd5));
    handshake();

    // A coin at cycle 10 restarts the timeout.
    select(6'd7);
    coin(12'd5);
    step(9);
    coin(12'd5);
    step(15);
    check_val("tmo2_not_yet", {vif.out_valid, 12'(vif.credit)}, 32'd10);
    step();
    check_val("tmo2_res", dut_res(), res_word(1'b1, 2'd2, 6'd7, 12'd10));
    handshake();

    // Stall in RESULT: outputs hold, coins rejected.
    select(6'd7);
    coin(12'd10);
    vif.cancel = 1'b1;
    vif.coin_valid = 1'b1;
    vif.coin_value = 12'd5;
    step();
    vif.cancel = 1'b0;
    vif.coin_valid = 1'b0;
    check_val("cancel_coin_rej", {vif.coin_rej, 12'(vif.credit)}, 32'h100A);
    check_val("cancel_coin_res", dut_res(), res_word(1'b1, 2'd1, 6'd7, 12'd10));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        vif.coin_valid = 1'b1;
        vif.coin_value = 12'd10;
      end
      step();
      vif.coin_valid = 1'b0;
      check_val($sformatf("stall_%0d", i), dut_res(), res_word(1'b1, 2'd1, 6'd7, 12'd10));
      check_val($sformatf("stall_rej_%0d", i), {vif.coin_rej, 12'(vif.credit)},
                (i == 2) ? 32'h100A : 32'h000A);
    end
    handshake();

    // Zero coin and overflow coin are rejected; then an idle cancel refunds.
    coin(12'd0);
    check_val("coin_zero", {vif.coin_rej, 12'(vif.credit)}, 32'h1000);
    coin(12'd4000);
    check_val("coin_4000", {vif.coin_rej, 12'(vif.credit)}, 32'd4000);
    coin(12'd100);
    check_val("coin_ovf", {vif.coin_rej, 12'(vif.credit)}, 32'h1000 | 32'd4000);
    vif.cancel = 1'b1;
    step();
    vif.cancel = 1'b0;
    check_val("idle_cancel", dut_res(), res_word(1'b1, 2'd1, 6'd63, 12'd4000));
    handshake();
    check_val("idle_cancel_clr", vif.credit, 32'd0);

    // Price 0 dispenses the cycle after selection with full change.
    coin(12'd7);
    select(6'd9);
    step();
    check_val("price0", dut_res(), res_word(1'b1, 2'd0, 6'd9, 12'd7));
    handshake();

    // Reset mid-transaction discards credit.
    select(6'd7);
    coin(12'd30);
    check_val("pre_rst_credit", vif.credit, 32'd30);
    rstn = 1'b0;
    #1;
    check_val("rst_mid", {vif.busy, 12'(vif.credit)}, 32'd0);
    step(2);
    rstn = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vif.out_valid) seen_valid = 1'b1;
    end
    check_val("rst_no_result", {seen_valid, vif.busy}, 32'd0);
    cfg_read(6'd3);
    check_val("rst_entry_clr", vif.cfg_rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
